// File: rtl/unary_deshift_counter.sv
// unary_deshift_counter
//   Collects a window of N shift-qualified serial bits. It counts the ones in
//   the window and keeps the raw bits. The result is then held until the
//   consumer accepts it with a valid/ready handshake.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   request to open a new window (IDLE, or HOLD with handshake)
//   in           in   serial unary bit
//   shift        in   qualifies in as valid this cycle
//   busy         out  high while a window is collecting
//   count        out  number of ones in the completed window (W bits)
//   bits         out  raw window bits; first received at bits[0], last at bits[N-1]
//   count_valid  out  count and bits are valid and held
//   count_ready  in   consumer accepts the result
//   drop_err     out  sticky: a shift arrived outside COLLECT
//
// All outputs come straight from flops.
module unary_deshift_counter #(
  parameter  int N = 16,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in,
  input  logic         shift,
  output logic         busy,
  output logic [W-1:0] count,
  output logic [N-1:0] bits,
  output logic         count_valid,
  input  logic         count_ready,
  output logic         drop_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ones_q, ones_d;
  logic [W-1:0]   pos_q, pos_d;
  logic [N-1:0]   bits_q, bits_d;
  logic           drop_q, drop_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    pos_d   = pos_q;
    bits_d  = bits_q;
    drop_d  = drop_q;

    case (state_q)
      IDLE: begin
        // A shift coinciding with an accepted start is ignored, not flagged.
        if (start) begin
          state_d = COLLECT;
          ones_d  = '0;
          pos_d   = '0;
          bits_d  = '0;
          drop_d  = 1'b0;
        end else if (shift) begin
          drop_d = 1'b1;
        end
      end

      COLLECT: begin
        if (shift) begin
          bits_d = {in, bits_q[N-1:1]};
          ones_d = ones_q + W'(in);
          pos_d  = pos_q + W'(1);
          // The edge accepting the Nth bit lands directly in HOLD.
          if (pos_q == W'(N - 1)) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (count_ready && start) begin
          // Back-to-back: skip IDLE entirely.
          state_d = COLLECT;
          ones_d  = '0;
          pos_d   = '0;
          bits_d  = '0;
          drop_d  = 1'b0;
        end else begin
          if (count_ready) begin
            state_d = IDLE;
          end
          if (shift) begin
            drop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == COLLECT);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ones_q  <= '0;
      pos_q   <= '0;
      bits_q  <= '0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      pos_q   <= pos_d;
      bits_q  <= bits_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign count       = ones_q;
  assign bits        = bits_q;
  assign count_valid = valid_q;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_unary_deshift_counter.sv
module tb_unary_deshift_counter;

  localparam int N = 8;
  localparam int W = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         in = 1'b0;
  logic         shift = 1'b0;
  logic         busy;
  logic [W-1:0] count;
  logic [N-1:0] bits;
  logic         count_valid;
  logic         count_ready = 1'b0;
  logic         drop_err;

  int vectors = 0;
  int errors  = 0;

  // Stream 1,0,1,1,0,0,1,0 : bit i of this byte is the i-th bit sent.
  localparam logic [7:0] SEQ_A = 8'b0100_1101;

  unary_deshift_counter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in         (in),
    .shift      (shift),
    .busy       (busy),
    .count      (count),
    .bits       (bits),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: open a window and send nb bits of seq without gaps.
  task automatic drive_window(input logic [7:0] seq, input int nb);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      shift = 1'b1;
      in    = seq[i];
      step();
    end
    shift = 1'b0;
    in    = 1'b0;
  endtask

  task automatic handshake();
    count_ready = 1'b1;
    step();
    count_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", count_valid); end
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (bits !== 8'h00) begin errors++; $display("FAIL reset_bits got %b want 0", bits); end
    vectors++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop_err); end
    @(negedge clk);
    reset = 1'b0;
    // First start after release is taken on the next edge.
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_start got busy=%b want 1", busy); end
    // Return to IDLE by completing a zero window.
    for (int i = 0; i < N; i++) begin shift = 1'b1; in = 1'b0; step(); end
    shift = 1'b0;
    handshake();
  endtask

  task automatic test_basic();
    drive_window(SEQ_A, 7);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy7 got %b want 1", busy); end
    vectors++; if (count_valid !== 1'b0) begin errors++; $display("FAIL basic_valid7 got %b want 0", count_valid); end
    shift = 1'b1; in = SEQ_A[7];
    step();
    shift = 1'b0; in = 1'b0;
    vectors++; if (count_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", count_valid); end
    vectors++; if (count !== 4'd4) begin errors++; $display("FAIL basic_count got %0d want 4", count); end
    vectors++; if (bits !== 8'b01001101) begin errors++; $display("FAIL basic_bits got %b want 01001101", bits); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    handshake();
    vectors++; if (count_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b want 0", count_valid); end
  endtask

  task automatic test_gaps();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      shift = 1'b1;
      in    = SEQ_A[i];
      step();
      shift = 1'b0;
      in    = 1'b0;
      if (i < N - 1) begin
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy bit%0d got %b want 1", i, busy); end
        for (int g = 0; g < 3; g++) begin
          // start during COLLECT must not restart the window
          if (i == 3 && g == 1) start = 1'b1;
          step();
          start = 1'b0;
          vectors++; if (busy !== 1'b1 || count_valid !== 1'b0) begin
            errors++; $display("FAIL gap_hold bit%0d gap%0d got busy=%b valid=%b want 1/0", i, g, busy, count_valid);
          end
        end
      end
    end
    vectors++; if (count_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", count_valid); end
    vectors++; if (count !== 4'd4) begin errors++; $display("FAIL gap_count got %0d want 4", count); end
    vectors++; if (bits !== 8'b01001101) begin errors++; $display("FAIL gap_bits got %b want 01001101", bits); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end got %b want 0", busy); end
    handshake();
  endtask

  task automatic test_hold();
    drive_window(8'hFF, N);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (count !== 4'd8 || count_valid !== 1'b1 || bits !== 8'hFF) begin
        errors++; $display("FAIL hold_stable cyc%0d got count=%0d valid=%b bits=%b want 8/1/11111111", c, count, count_valid, bits);
      end
      // start without handshake is ignored
      start = (c == 2);
      step();
      start = 1'b0;
    end
    vectors++; if (count !== 4'd8 || count_valid !== 1'b1) begin
      errors++; $display("FAIL hold_after_start got count=%0d valid=%b want 8/1", count, count_valid);
    end
    handshake();
    vectors++; if (count_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_to_idle got valid=%b busy=%b want 0/0", count_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    drive_window(SEQ_A, N);
    vectors++; if (count !== 4'd4) begin errors++; $display("FAIL b2b_first_count got %0d want 4", count); end
    count_ready = 1'b1;
    start       = 1'b1;
    step();
    count_ready = 1'b0;
    start       = 1'b0;
    vectors++; if (busy !== 1'b1 || count_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_direct got busy=%b valid=%b want 1/0", busy, count_valid);
    end
    vectors++; if (count !== 4'd0 || bits !== 8'h00) begin
      errors++; $display("FAIL b2b_cleared got count=%0d bits=%b want 0/0", count, bits);
    end
    for (int i = 0; i < N; i++) begin shift = 1'b1; in = 1'b0; step(); end
    shift = 1'b0;
    vectors++; if (count_valid !== 1'b1 || count !== 4'd0 || bits !== 8'h00) begin
      errors++; $display("FAIL b2b_second got valid=%b count=%0d bits=%b want 1/0/0", count_valid, count, bits);
    end
    vectors++; if (drop_err !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", drop_err); end
    handshake();
  endtask

  task automatic test_drop();
    shift = 1'b1; in = 1'b1;
    step();
    shift = 1'b0; in = 1'b0;
    vectors++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_set got %b want 1", drop_err); end
    step();
    vectors++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", drop_err); end
    // shift together with start is ignored, neither counted nor flagged
    start = 1'b1; shift = 1'b1; in = 1'b1;
    step();
    start = 1'b0; shift = 1'b0; in = 1'b0;
    vectors++; if (drop_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_clear got drop=%b busy=%b want 0/1", drop_err, busy);
    end
    for (int i = 0; i < N; i++) begin shift = 1'b1; in = SEQ_A[i]; step(); end
    shift = 1'b0; in = 1'b0;
    vectors++; if (count !== 4'd4 || bits !== 8'b01001101) begin
      errors++; $display("FAIL drop_result got count=%0d bits=%b want 4/01001101", count, bits);
    end
    // shift while holding a result is also dropped and flagged
    shift = 1'b1; in = 1'b1;
    step();
    shift = 1'b0; in = 1'b0;
    vectors++; if (drop_err !== 1'b1 || count !== 4'd4 || count_valid !== 1'b1) begin
      errors++; $display("FAIL drop_in_hold got drop=%b count=%0d valid=%b want 1/4/1", drop_err, count, count_valid);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    drive_window(8'hFF, 5);
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || count_valid !== 1'b0 || count !== 4'd0 || bits !== 8'h00 || drop_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got busy=%b valid=%b count=%0d bits=%b drop=%b want all 0", busy, count_valid, count, bits, drop_err);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    vectors++; if (count_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_partial got valid=%b busy=%b want 0/0", count_valid, busy);
    end
    drive_window(SEQ_A, N);
    vectors++; if (count_valid !== 1'b1 || count !== 4'd4 || bits !== 8'b01001101) begin
      errors++; $display("FAIL rstmid_window got valid=%b count=%0d bits=%b want 1/4/01001101", count_valid, count, bits);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
